// File: rtl/cntr_checker.sv
// Window checker for the three-counter / clock-divider block: compares each
// counter bus against its expected sequence and accumulates wrap/error/gate stats.
module cntr_checker #(
  parameter int WIDTH     = 3,
  parameter int ERR_W     = 8,
  parameter int CYC_W     = 8,
  parameter int CHECK_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               clr,
  input  logic [WIDTH-1:0]   cntr_in1,
  input  logic [WIDTH-1:0]   cntr_in2,
  input  logic [WIDTH-1:0]   cntr_in3,
  input  logic               select_3,
  input  logic [WIDTH-1:0]   bypass_in,
  input  logic               gate_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_flag,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [CYC_W-1:0]   first_err_cyc,
  output logic [CYC_W-1:0]   wrap_cnt1,
  output logic [CYC_W-1:0]   gate_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CHECK, S_FIN} state_t;

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CHECK_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [WIDTH-1:0]  prev1, prev2, prev3;
  logic              prev_sel, prev_gate;

  logic [WIDTH-1:0]  p1_inc, p2_inc, p3_inc;
  logic              err1, err2, err3, any_err, wrap_hit, gate_rise;

  always_comb begin
    p1_inc    = prev1 + WIDTH'(1);
    p2_inc    = prev2 + WIDTH'(1);
    p3_inc    = prev3 + WIDTH'(1);
    err1      = (cntr_in1 != p1_inc);
    err2      = (cntr_in2 != p2_inc);
    // Stream 3: bypass compare when deselected; first counter cycle after a switch is a resync
    err3      = select_3 ? (prev_sel && (cntr_in3 != p3_inc)) : (cntr_in3 != bypass_in);
    any_err   = err1 | err2 | err3;
    wrap_hit  = (prev1 == ONES_W) && (cntr_in1 == '0);
    gate_rise = gate_in && !prev_gate;
  end

  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cyc           <= '0;
      prev1         <= '0;
      prev2         <= '0;
      prev3         <= '0;
      prev_sel      <= 1'b0;
      prev_gate     <= 1'b0;
      err_flag      <= '0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
      wrap_cnt1     <= '0;
      gate_cnt      <= '0;
    end else if (clr) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cyc           <= '0;
      prev1         <= '0;
      prev2         <= '0;
      prev3         <= '0;
      prev_sel      <= 1'b0;
      prev_gate     <= 1'b0;
      err_flag      <= '0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
      wrap_cnt1     <= '0;
      gate_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          prev1         <= cntr_in1;
          prev2         <= cntr_in2;
          prev3         <= cntr_in3;
          prev_sel      <= select_3;
          prev_gate     <= gate_in;
          err_flag      <= '0;
          err_cnt       <= '0;
          first_err_cyc <= '0;
          wrap_cnt1     <= '0;
          gate_cnt      <= '0;
          cyc           <= '0;
          state         <= S_CHECK;
        end
        S_CHECK: begin
          prev1     <= cntr_in1;
          prev2     <= cntr_in2;
          prev3     <= cntr_in3;
          prev_sel  <= select_3;
          prev_gate <= gate_in;
          err_flag  <= err_flag | {err3, err2, err1};
          if (any_err) begin
            // err_cnt saturates and never returns to 0, so zero marks "no error yet"
            if (err_cnt == '0)
              first_err_cyc <= cyc;
            if (err_cnt != ERR_MAX)
              err_cnt <= err_cnt + ERR_W'(1);
          end
          if (wrap_hit && (wrap_cnt1 != CYC_MAX))
            wrap_cnt1 <= wrap_cnt1 + CYC_W'(1);
          if (gate_rise && (gate_cnt != CYC_MAX))
            gate_cnt <= gate_cnt + CYC_W'(1);
          if (cyc == LAST_CYC) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        S_FIN: begin
          if (start) begin
            state <= S_ARM;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
